// File: rtl/controller_serial_reader_pkg.sv
// ============================================================================
// Module : controller_serial_reader_pkg
// Brief  : Shared types and button bit positions for the gamepad serial reader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package controller_serial_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_DONE  = 3'd4
    } ctrl_state_t;

    typedef logic [7:0] data_t;

    localparam int unsigned BTN_A      = 7;
    localparam int unsigned BTN_B      = 6;
    localparam int unsigned BTN_SELECT = 5;
    localparam int unsigned BTN_START  = 4;
    localparam int unsigned BTN_UP     = 3;
    localparam int unsigned BTN_DOWN   = 2;
    localparam int unsigned BTN_LEFT   = 1;
    localparam int unsigned BTN_RIGHT  = 0;

    // The first bit shifted out (A) lands in the MSB.
    function automatic logic [2:0] bit_slot(input logic [2:0] k);
        return 3'd7 - k;
    endfunction

endpackage

`default_nettype wire

// File: rtl/controller_serial_reader_if.sv
// ============================================================================
// Module : controller_serial_reader_if
// Brief  : Pad-line and CPU-side signals of the gamepad serial reader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface controller_serial_reader_if #(
    parameter int NUM_CONTROLLERS = 2
);
    logic                         start_fetch_i;
    logic                         clk_o;
    logic                         latch_o;
    logic [NUM_CONTROLLERS-1:0]   serial_LIST_ni;
    logic [NUM_CONTROLLERS*8-1:0] data_LIST_o;
    logic                         busy_o;
    logic                         valid_o;

    modport master (
        output start_fetch_i, serial_LIST_ni,
        input  clk_o, latch_o, data_LIST_o, busy_o, valid_o
    );

    modport slave (
        input  start_fetch_i, serial_LIST_ni,
        output clk_o, latch_o, data_LIST_o, busy_o, valid_o
    );
endinterface

`default_nettype wire

// File: rtl/controller_serial_reader_shift_reg.sv
// ============================================================================
// Module : controller_shift_reg
// Brief  : Per-pad capture register; stores the inverted serial bit at 7-k.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module controller_shift_reg
    import controller_serial_reader_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       sample_en,
    input  wire logic [2:0] bit_idx,
    input  wire logic       serial_ni,
    output data_t           pad_byte
);
    data_t r_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte <= '0;
        end else if (sample_en) begin
            r_byte[bit_slot(bit_idx)] <= ~serial_ni;
        end
    end

    assign pad_byte = r_byte;
endmodule

`default_nettype wire

// File: rtl/controller_serial_reader.sv
// ============================================================================
// Module : controller_serial_reader
// Brief  : Polls NES-style pads once per start edge, publishes one byte per pad.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module controller_serial_reader
    import controller_serial_reader_pkg::*;
#(
    parameter int NUM_CONTROLLERS = 2,
    parameter int CLK_DIV         = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    controller_serial_reader_if.slave  bus
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(CLK_DIV - 1);

    ctrl_state_t                  r_state, w_next_state;
    logic [CNT_W-1:0]             r_cnt;
    logic                         r_latch_half;
    logic [2:0]                   r_k;
    logic                         r_start_q;
    logic                         r_clk_o, r_latch_o, r_busy, r_valid;
    logic [NUM_CONTROLLERS*8-1:0] r_data;

    logic  w_phase_end, w_start, w_sample_en;
    data_t w_pad_byte [NUM_CONTROLLERS];

    assign w_phase_end = (r_cnt == c_cnt_last);
    assign w_start     = bus.start_fetch_i && !r_start_q && (r_state == ST_IDLE);
    assign w_sample_en = (r_state == ST_LOW) && w_phase_end;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_next_state = ST_LATCH;
            ST_LATCH: if (w_phase_end && r_latch_half) w_next_state = ST_LOW;
            ST_LOW:   if (w_phase_end) w_next_state = ST_HIGH;
            ST_HIGH:  if (w_phase_end) w_next_state = (r_k == 3'd7) ? ST_DONE : ST_LOW;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_latch_half <= 1'b0;
            r_k          <= 3'd0;
            r_start_q    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_start_q <= bus.start_fetch_i;
            // Every state change happens on a phase end (or from IDLE/DONE where cnt is 0),
            // so wrapping on phase end doubles as the clear-on-entry.
            if (r_state == ST_IDLE || r_state == ST_DONE || w_phase_end)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CNT_W'(1);
            // LATCH spans two divider periods without widening the counter.
            if (r_state != ST_LATCH)
                r_latch_half <= 1'b0;
            else if (w_phase_end)
                r_latch_half <= 1'b1;
            if (w_start)
                r_k <= 3'd0;
            else if (r_state == ST_HIGH && w_phase_end && r_k != 3'd7)
                r_k <= r_k + 3'd1;
        end
    end

    // Outputs are registered from the next state so the pad lines never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_o   <= 1'b0;
            r_latch_o <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_data    <= '0;
        end else begin
            r_clk_o   <= (w_next_state == ST_HIGH);
            r_latch_o <= (w_next_state == ST_LATCH);
            r_busy    <= (w_next_state != ST_IDLE);
            r_valid   <= (w_next_state == ST_DONE);
            if (w_next_state == ST_DONE) begin
                for (int i = 0; i < NUM_CONTROLLERS; i++)
                    r_data[8*i +: 8] <= w_pad_byte[i];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CONTROLLERS; gi++) begin : g_pad
        controller_shift_reg u_shift (
            .clk       (clk),
            .rst       (rst),
            .sample_en (w_sample_en),
            .bit_idx   (r_k),
            .serial_ni (bus.serial_LIST_ni[gi]),
            .pad_byte  (w_pad_byte[gi])
        );
    end

    assign bus.clk_o       = r_clk_o;
    assign bus.latch_o     = r_latch_o;
    assign bus.busy_o      = r_busy;
    assign bus.valid_o     = r_valid;
    assign bus.data_LIST_o = r_data;
endmodule

`default_nettype wire

// File: tb/tb_controller_serial_reader.sv
// ============================================================================
// Module : tb_controller_serial_reader
// Brief  : Directed bench over four divider settings with behavioural pad models.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_controller_serial_reader;
    import controller_serial_reader_pkg::*;

    localparam int NDUT = 4;

    function automatic int div_of(input int d);
        case (d)
            0:       return 1;
            1:       return 4;
            2:       return 2;
            default: return 7;
        endcase
    endfunction

    logic clk, rst, clr;
    logic [NDUT-1:0]       start;
    logic [NDUT-1:0][15:0] pad_byte;
    logic [NDUT-1:0][1:0]  absent;

    logic [NDUT-1:0]       clk_o_v, latch_v, busy_v, valid_v;
    logic [NDUT-1:0][15:0] data_v, n_busy_v, n_valid_v, n_lrise_v, n_crise_v, n_err_v;

    int n_total = 0;
    int n_bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        controller_serial_reader_if #(.NUM_CONTROLLERS(2)) bus ();
        logic [7:0]  sh0, sh1;
        logic        clk_d, latch_d;
        logic [15:0] n_busy, n_valid, n_lrise, n_crise, n_err;

        assign bus.start_fetch_i  = start[g];
        assign bus.serial_LIST_ni = {absent[g][1] | ~sh1[7], absent[g][0] | ~sh0[7]};

        controller_serial_reader #(.NUM_CONTROLLERS(2), .CLK_DIV(div_of(g))) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        // Pad model: parallel load while latched, shift on each clk_o rise.
        always @(negedge clk) begin
            if (bus.latch_o) begin
                sh0 <= pad_byte[g][7:0];
                sh1 <= pad_byte[g][15:8];
            end else if (bus.clk_o && !clk_d) begin
                sh0 <= {sh0[6:0], 1'b0};
                sh1 <= {sh1[6:0], 1'b0};
            end
            clk_d   <= bus.clk_o;
            latch_d <= bus.latch_o;
            if (rst && clr) n_err <= '0;
            else if (bus.latch_o && (bus.clk_o || clk_d)) n_err <= n_err + 16'd1;
            if (clr) begin
                n_busy <= '0; n_valid <= '0; n_lrise <= '0; n_crise <= '0;
            end else begin
                n_busy  <= n_busy  + 16'(bus.busy_o);
                n_valid <= n_valid + 16'(bus.valid_o);
                if (bus.latch_o && !latch_d) n_lrise <= n_lrise + 16'd1;
                if (bus.clk_o && !clk_d)     n_crise <= n_crise + 16'd1;
            end
        end

        assign clk_o_v[g]   = bus.clk_o;
        assign latch_v[g]   = bus.latch_o;
        assign busy_v[g]    = bus.busy_o;
        assign valid_v[g]   = bus.valid_o;
        assign data_v[g]    = bus.data_LIST_o;
        assign n_busy_v[g]  = n_busy;
        assign n_valid_v[g] = n_valid;
        assign n_lrise_v[g] = n_lrise;
        assign n_crise_v[g] = n_crise;
        assign n_err_v[g]   = n_err;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts();
        clr = 1'b1;
        tick(2);
        clr = 1'b0;
    endtask

    task automatic wait_valid(input int d, input int budget);
        for (int c = 0; c < budget && n_valid_v[d] == 0; c++) tick(1);
        check($sformatf("valid_seen_d%0d", d), 32'(n_valid_v[d] != 0), 32'd1);
    endtask

    task automatic poll(input int d, input logic [15:0] b, input logic [15:0] exp);
        pad_byte[d] = b;
        clear_counts();
        start[d] = 1'b1;
        tick(1);
        start[d] = 1'b0;
        wait_valid(d, 20 * div_of(d) + 20);
        tick(3);
        check($sformatf("data_d%0d", d),   32'(data_v[d]),    32'(exp));
        check($sformatf("valid_d%0d", d),  32'(n_valid_v[d]), 32'd1);
        check($sformatf("busy_d%0d", d),   32'(n_busy_v[d]),  32'(18 * div_of(d) + 1));
        check($sformatf("clkpul_d%0d", d), 32'(n_crise_v[d]), 32'd8);
        check($sformatf("latch_d%0d", d),  32'(n_lrise_v[d]), 32'd1);
    endtask

    initial begin
        logic [15:0] vec [8];
        vec = '{16'h3CA5, 16'h0000, 16'hFFFF, 16'h5A96, 16'h8001, 16'h7E18, 16'hC3D2, 16'h1248};

        rst = 1'b1; clr = 1'b1; start = '0; pad_byte = '0; absent = '0;
        tick(4);
        rst = 1'b0; clr = 1'b0;
        tick(1);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("rst_state_d%0d", d),
                  {clk_o_v[d], latch_v[d], busy_v[d], valid_v[d]}, 32'd0);
            check($sformatf("rst_data_d%0d", d), 32'(data_v[d]), 32'd0);
        end

        // 1: CLK_DIV=1, latch timing and byte assembly
        pad_byte[0] = 16'h3CA5;
        clear_counts();
        start[0] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        check("t1_latch_c1", 32'(latch_v[0]), 32'd1);
        check("t1_busy_c1",  32'(busy_v[0]),  32'd1);
        tick(1);
        check("t1_latch_c2", 32'(latch_v[0]), 32'd1);
        tick(1);
        check("t1_latch_c3", 32'(latch_v[0]), 32'd0);
        wait_valid(0, 40);
        tick(3);
        check("t1_data",   32'(data_v[0]),    32'h3CA5);
        check("t1_busy",   32'(n_busy_v[0]),  32'd19);
        check("t1_clkpul", 32'(n_crise_v[0]), 32'd8);

        // 2: start held high does not retrigger
        pad_byte[1] = 16'h1E2D;
        clear_counts();
        start[1] = 1'b1;
        tick(200);
        start[1] = 1'b0;
        tick(20);
        check("t2_busy",  32'(n_busy_v[1]),  32'd73);
        check("t2_valid", 32'(n_valid_v[1]), 32'd1);
        check("t2_latch", 32'(n_lrise_v[1]), 32'd1);
        check("t2_data",  32'(data_v[1]),    32'h1E2D);

        // 3: an edge mid-poll is dropped, a later one works
        pad_byte[1] = 16'h6699;
        clear_counts();
        start[1] = 1'b1; tick(1); start[1] = 1'b0;
        tick(9);
        start[1] = 1'b1; tick(1); start[1] = 1'b0;
        tick(150);
        check("t3_valid", 32'(n_valid_v[1]), 32'd1);
        check("t3_latch", 32'(n_lrise_v[1]), 32'd1);
        check("t3_data",  32'(data_v[1]),    32'h6699);
        poll(1, 16'h4321, 16'h4321);

        // 4: reset during the fourth clock pulse aborts and clears
        poll(1, 16'hFFFF, 16'hFFFF);
        pad_byte[1] = 16'h0F0F;
        clear_counts();
        start[1] = 1'b1; tick(1); start[1] = 1'b0;
        for (int c = 0; c < 100 && n_crise_v[1] < 4; c++) tick(1);
        check("t4_in_high", 32'(clk_o_v[1]), 32'd1);
        rst = 1'b1;
        tick(1);
        check("t4_rst_state", {clk_o_v[1], latch_v[1], busy_v[1]}, 32'd0);
        check("t4_rst_data",  32'(data_v[1]), 32'd0);
        rst = 1'b0;
        clear_counts();
        tick(100);
        check("t4_no_valid", 32'(n_valid_v[1]), 32'd0);
        check("t4_no_busy",  32'(n_busy_v[1]),  32'd0);
        poll(1, 16'h1234, 16'h1234);

        // 5: absent pad reads zero; A on bit7, Right on bit0
        absent[0] = 2'b10;
        poll(0, 16'h5581, 16'h0081);
        check("t5_btn_a",     32'(data_v[0][BTN_A]),     32'd1);
        check("t5_btn_right", 32'(data_v[0][BTN_RIGHT]), 32'd1);
        check("t5_btn_start", 32'(data_v[0][BTN_START]), 32'd0);
        absent[0] = 2'b00;
        absent[3] = 2'b10;
        poll(3, 16'hAA81, 16'h0081);
        absent[3] = 2'b00;

        // 6: table of bytes across all divider settings
        for (int r = 0; r < 2; r++)
            for (int d = 0; d < NDUT; d++)
                poll(d, vec[(r * NDUT + d) % 8] ^ 16'(r * 16'h0F0F),
                     vec[(r * NDUT + d) % 8] ^ 16'(r * 16'h0F0F));

        for (int d = 0; d < NDUT; d++)
            check($sformatf("clk_in_latch_d%0d", d), 32'(n_err_v[d]), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire
